memory_cycle: RTL and testbench
===============================

// Module: memory_cycle
// PURPOSE
//  MEM pipeline stage, directly downstream of the execute stage. Consumes the E->M control/data bundle.
//  Drives a single-outstanding data-memory req/ack bus: byte-enable generation for SB/SH/SW, extraction and extension for LB/LH/LW/LBU/LHU.
//  Stalls upstream while an access is pending. Registers the M->W bundle for writeback.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max WAIT cycles before an access is aborted as a bus error (1..65535)
// PORTS
//  clk           in   1   stage clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  RegWriteM     in   1   instruction writes rd
//  MemWriteM     in   1   store
//  ResultSrcM    in   1   load (writeback selects ReadData)
//  Funct3M       in   3   RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  RD_M          in   5   destination register
//  PCPlus4M      in   32  PC+4 passthrough
//  WriteDataM    in   32  store data (rs2)
//  ALU_ResultM   in   32  effective address / ALU result
//  StallM        out  1   hold execute stage and all upstream stages; inputs must stay stable while high
//  dmem_req      out  1   access request
//  dmem_we       out  1   1 = write
//  dmem_addr     out  32  word-aligned address {ALU_ResultM[31:2],2'b00}
//  dmem_be       out  4   byte enables
//  dmem_wdata    out  32  lane-replicated store data
//  dmem_ack      in   1   one-cycle completion; dmem_rdata valid in the same cycle
//  dmem_rdata    in   32  read word
//  RegWriteW     out  1   registered to WB
//  ResultSrcW    out  1   registered to WB
//  RD_W          out  5   registered to WB
//  PCPlus4W      out  32  registered to WB
//  ALU_ResultW   out  32  registered to WB
//  ReadDataW     out  32  extended load data
//  BusErrW       out  1   one-cycle pulse: the access in W timed out
// BEHAVIOUR
//  - Reset: all W outputs 0; FSM enters IDLE; timeout counter cleared. dmem_req and StallM drop to 0 immediately (async), including mid-access.
//  - memop = MemWriteM|ResultSrcM. Non-memop: W bundle captured next edge (latency 1); StallM=0; no bus request.
//  - FSM IDLE: dmem_req = memop (combinational). If dmem_ack in the same cycle: complete, capture W, stay IDLE, StallM=0.
//    Otherwise: StallM=1, next state WAIT.
//  - FSM WAIT: dmem_req=1 and StallM=1; req/addr/we/be/wdata are held stable. Each cycle, W captures a bubble (RegWriteW=0, BusErrW=0).
//    On dmem_ack: capture W with ReadDataW, StallM=0 that cycle, return to IDLE.
//  - Timeout: the counter increments each cycle in WAIT. When it reaches TIMEOUT_CYCLES with no ack: dmem_req drops; W captures the
//    instruction with RegWriteW=0 and BusErrW=1; StallM=0; return to IDLE. An ack arriving on the timeout cycle wins (normal completion).
//  - Store byte enables: B -> 0001<<addr[1:0]; H -> 0011<<{addr[1],1'b0}; W -> 1111. wdata = {4{b}} / {2{h}} / word.
//  - Load: select the byte/half by addr[1:0] and addr[1]; sign-extend for B/H, zero-extend for BU/HU.
//    Any other Funct3 on a load is treated as W.
//  - Non-load W entries set ReadDataW=0.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: misaligned H (addr[0]=1) or W (addr[1:0]!=0) raises no bus request.
//    W captures RegWriteW=0 and MisalignW=1 (extra 1-bit output, one-cycle pulse); latency 1, no stall.
//  Not defined: misalignment is ignored. Address low bits are truncated per the lane rules above; no MisalignW port.
// STRUCTURE
//  core_pkg (shared): FUNCT3_B/H/W/BU/HU constants; mem_state_t {IDLE, WAIT}; byte-enable width constant.
//  Sub-module lsu_align: combinational; owns store lane steering/BE and load extract/extend. Shared with future cache work.
//  Top level: FSM, timeout counter, W register.
// TESTING
//  1. SW addr 0x100, data 0xDEADBEEF, ack same cycle -> be=1111, wdata=0xDEADBEEF, StallM never high, RegWriteW=0.
//  2. LB addr 0x103, rdata 0x80112233, ack after 3 cycles -> StallM high 3 cycles, 3 bubbles, then ReadDataW=0xFFFFFF80.
//  3. LHU addr 0x202, rdata 0x9ABC1234 -> ReadDataW=0x00009ABC. SB addr 0x01, data 0x55 -> be=0010, wdata=0x55555555.
//  4. TIMEOUT_CYCLES=4, no ack -> req held 5 cycles, then BusErrW=1 for 1 cycle, RegWriteW=0, StallM=0; ack on the 4th count -> normal completion.
//  5. rst asserted in WAIT -> dmem_req=0, StallM=0 immediately; W outputs 0; after release an ALU op (x5) writes back 1 cycle later.
//  6. MISALIGN_TRAP_EN, LW addr 0x102 -> no dmem_req, MisalignW=1, RegWriteW=0; without the macro -> word read at 0x100.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and state type for the MEM stage
package core_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    localparam int BE_WIDTH = 4;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane steering / byte enables and load extract / extend
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]          funct3,
    input  logic [1:0]          addr_lo,
    input  logic [31:0]         store_data,
    input  logic [31:0]         rdata,
    output logic [BE_WIDTH-1:0] be,
    output logic [31:0]         wdata,
    output logic [31:0]         load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        // Store width comes from funct3[1:0] only; unsigned codes never reach a store.
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase

        case (funct3)
            FUNCT3_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_H:  load_data = {{16{half_sel[15]}}, half_sel};
            FUNCT3_BU: load_data = {24'h0, byte_sel};
            FUNCT3_HU: load_data = {16'h0, half_sel};
            default:   load_data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - MEM stage: dmem req/ack FSM, timeout, M->W register
// Optional feature: MISALIGN_TRAP_EN (misaligned H/W trap, adds MisalignW output).
module memory_cycle
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RegWriteM,
    input  logic                MemWriteM,
    input  logic                ResultSrcM,
    input  logic [2:0]          Funct3M,
    input  logic [4:0]          RD_M,
    input  logic [31:0]         PCPlus4M,
    input  logic [31:0]         WriteDataM,
    input  logic [31:0]         ALU_ResultM,
    output logic                StallM,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [31:0]         dmem_addr,
    output logic [BE_WIDTH-1:0] dmem_be,
    output logic [31:0]         dmem_wdata,
    input  logic                dmem_ack,
    input  logic [31:0]         dmem_rdata,
    output logic                RegWriteW,
    output logic                ResultSrcW,
    output logic [4:0]          RD_W,
    output logic [31:0]         PCPlus4W,
    output logic [31:0]         ALU_ResultW,
    output logic [31:0]         ReadDataW,
`ifdef MISALIGN_TRAP_EN
    output logic                MisalignW,
`endif
    output logic                BusErrW
);

    mem_state_t  state, next_state;
    logic [15:0] wait_cnt;
    logic        memop, trap, bus_op, timeout;
    logic        req, stall;
    logic        w_reg_write, w_bus_err, w_misalign;
    logic [31:0] w_read_data, load_data;

    lsu_align u_lsu_align (
        .funct3    (Funct3M),
        .addr_lo   (ALU_ResultM[1:0]),
        .store_data(WriteDataM),
        .rdata     (dmem_rdata),
        .be        (dmem_be),
        .wdata     (dmem_wdata),
        .load_data (load_data)
    );

    assign memop = MemWriteM | ResultSrcM;

`ifdef MISALIGN_TRAP_EN
    logic is_byte, is_half;
    assign is_byte = (Funct3M == FUNCT3_B) || (Funct3M == FUNCT3_BU);
    assign is_half = (Funct3M == FUNCT3_H) || (Funct3M == FUNCT3_HU);
    assign trap    = memop & (is_half ? ALU_ResultM[0]
                                      : (!is_byte && ALU_ResultM[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign bus_op    = memop & ~trap;
    assign timeout   = (state == WAIT) && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign dmem_we   = MemWriteM;
    assign dmem_addr = {ALU_ResultM[31:2], 2'b00};
    // Gated by rst so a mid-access reset drops the bus and the stall without waiting for an edge.
    assign dmem_req  = req & ~rst;
    assign StallM    = stall & ~rst;

    always_comb begin
        next_state  = state;
        req         = 1'b0;
        stall       = 1'b0;
        w_reg_write = RegWriteM;
        w_bus_err   = 1'b0;
        w_misalign  = 1'b0;
        w_read_data = 32'h0;
        case (state)
            IDLE: begin
                if (bus_op) begin
                    req = 1'b1;
                    if (dmem_ack) begin
                        w_read_data = ResultSrcM ? load_data : 32'h0;
                    end else begin
                        stall       = 1'b1;
                        w_reg_write = 1'b0;
                        next_state  = WAIT;
                    end
                end else if (trap) begin
                    w_reg_write = 1'b0;
                    w_misalign  = 1'b1;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    w_read_data = ResultSrcM ? load_data : 32'h0;
                    next_state  = IDLE;
                end else if (timeout) begin
                    w_reg_write = 1'b0;
                    w_bus_err   = 1'b1;
                    next_state  = IDLE;
                end else begin
                    stall       = 1'b1;
                    w_reg_write = 1'b0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 16'h0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == WAIT && next_state == WAIT) ? wait_cnt + 16'h1 : 16'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'h0;
            PCPlus4W    <= 32'h0;
            ALU_ResultW <= 32'h0;
            ReadDataW   <= 32'h0;
            BusErrW     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            MisalignW   <= 1'b0;
`endif
        end else begin
            RegWriteW   <= w_reg_write;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= w_read_data;
            BusErrW     <= w_bus_err;
`ifdef MISALIGN_TRAP_EN
            MisalignW   <= w_misalign;
`endif
        end
    end

`ifndef MISALIGN_TRAP_EN
    logic unused_misalign;
    assign unused_misalign = w_misalign;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - directed self-checking bench for memory_cycle (TIMEOUT_CYCLES=4)
module tb_memory_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0;
    logic [2:0]  Funct3M = 3'b0;
    logic [4:0]  RD_M = 5'h0;
    logic [31:0] PCPlus4M = 32'h0, WriteDataM = 32'h0, ALU_ResultM = 32'h0;
    logic        StallM, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;
    logic        RegWriteW, ResultSrcW, BusErrW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_cycle #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
`ifdef MISALIGN_TRAP_EN
        .MisalignW(MisalignW),
`endif
        .BusErrW(BusErrW)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic rw, input logic mw, input logic rs, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd);
        RegWriteM   = rw;
        MemWriteM   = mw;
        ResultSrcM  = rs;
        Funct3M     = f3;
        RD_M        = rd;
        ALU_ResultM = alu;
        WriteDataM  = wd;
        PCPlus4M    = alu + 32'h4;
        dmem_ack    = 1'b0;
    endtask

    task automatic nop();
        op(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
    endtask

    initial begin
        #2;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(StallM), 32'h0);
        chk("rst_regwrite", 32'(RegWriteW), 32'h0);
        chk("rst_readdata", ReadDataW, 32'h0);
        step();
        step();
        rst = 1'b0;

        // Non-memop ALU result: no request, latency 1
        op(1'b1, 1'b0, 1'b0, 3'b000, 5'd3, 32'h0000_00AA, 32'h0);
        @(negedge clk);
        chk("alu_req", 32'(dmem_req), 32'h0);
        step();
        chk("alu_regwrite", 32'(RegWriteW), 32'h1);
        chk("alu_result", ALU_ResultW, 32'h0000_00AA);

        // SW with ack in the same cycle
        op(1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h100, 32'hDEAD_BEEF);
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("sw_req", 32'(dmem_req), 32'h1);
        chk("sw_we", 32'(dmem_we), 32'h1);
        chk("sw_be", 32'(dmem_be), 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        chk("sw_addr", dmem_addr, 32'h100);
        chk("sw_stall", 32'(StallM), 32'h0);
        step();
        chk("sw_regwrite", 32'(RegWriteW), 32'h0);
        chk("sw_readdata", ReadDataW, 32'h0);

        // LB at 0x103, ack after three stalled cycles
        op(1'b1, 1'b0, 1'b1, 3'b000, 5'd7, 32'h103, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("lb_stall%0d", i), 32'(StallM), 32'h1);
            chk($sformatf("lb_req%0d", i), 32'(dmem_req), 32'h1);
            step();
            chk($sformatf("lb_bubble%0d", i), 32'(RegWriteW), 32'h0);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h8011_2233;
        @(negedge clk);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_stall_done", 32'(StallM), 32'h0);
        step();
        chk("lb_data", ReadDataW, 32'hFFFF_FF80);
        chk("lb_regwrite", 32'(RegWriteW), 32'h1);
        chk("lb_rd", 32'(RD_W), 32'd7);

        // LHU at 0x202, ack same cycle
        op(1'b1, 1'b0, 1'b1, 3'b101, 5'd8, 32'h202, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h9ABC_1234;
        step();
        chk("lhu_data", ReadDataW, 32'h0000_9ABC);

        // LH at 0x200, negative half sign-extends
        op(1'b1, 1'b0, 1'b1, 3'b001, 5'd9, 32'h200, 32'h0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_8001;
        step();
        chk("lh_data", ReadDataW, 32'hFFFF_8001);

        // SB at 0x01
        op(1'b0, 1'b1, 1'b0, 3'b000, 5'd0, 32'h01, 32'h0000_0055);
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("sb_be", 32'(dmem_be), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h5555_5555);
        chk("sb_addr", dmem_addr, 32'h0);
        step();

        // SH at 0x02
        op(1'b0, 1'b1, 1'b0, 3'b001, 5'd0, 32'h02, 32'h1234_ABCD);
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        step();

        // Timeout: request held 5 cycles, then a bus-error pulse
        op(1'b1, 1'b0, 1'b1, 3'b010, 5'd10, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("to_stall%0d", i), 32'(StallM), 32'h1);
            chk($sformatf("to_req%0d", i), 32'(dmem_req), 32'h1);
            step();
            chk($sformatf("to_buserr%0d", i), 32'(BusErrW), 32'h0);
        end
        @(negedge clk);
        chk("to_last_req", 32'(dmem_req), 32'h1);
        chk("to_last_stall", 32'(StallM), 32'h0);
        step();
        chk("to_buserr", 32'(BusErrW), 32'h1);
        chk("to_regwrite", 32'(RegWriteW), 32'h0);
        nop();
        @(negedge clk);
        chk("to_req_drop", 32'(dmem_req), 32'h0);
        step();
        chk("to_buserr_pulse", 32'(BusErrW), 32'h0);

        // Ack on the timeout cycle wins
        op(1'b1, 1'b0, 1'b1, 3'b010, 5'd11, 32'h304, 32'h0);
        for (int i = 0; i < 4; i++) step();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1122_3344;
        step();
        chk("tack_buserr", 32'(BusErrW), 32'h0);
        chk("tack_regwrite", 32'(RegWriteW), 32'h1);
        chk("tack_data", ReadDataW, 32'h1122_3344);
        nop();
        step();

        // Reset in WAIT drops req/stall asynchronously
        op(1'b1, 1'b0, 1'b1, 3'b010, 5'd12, 32'h400, 32'h0);
        step();
        chk("rw_pc_before", PCPlus4W, 32'h404);
        chk("rw_stall_before", 32'(StallM), 32'h1);
        rst = 1'b1;
        #1;
        chk("rw_req", 32'(dmem_req), 32'h0);
        chk("rw_stall", 32'(StallM), 32'h0);
        chk("rw_pc", PCPlus4W, 32'h0);
        step();
        rst = 1'b0;
        op(1'b1, 1'b0, 1'b0, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
        step();
        chk("rw_alu_regwrite", 32'(RegWriteW), 32'h1);
        chk("rw_alu_rd", 32'(RD_W), 32'd5);
        chk("rw_alu_result", ALU_ResultW, 32'h0000_1234);

        // Misaligned LW at 0x102
        op(1'b1, 1'b0, 1'b1, 3'b010, 5'd13, 32'h102, 32'h0);
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 32'h0);
        chk("mis_stall", 32'(StallM), 32'h0);
        step();
        chk("mis_flag", 32'(MisalignW), 32'h1);
        chk("mis_regwrite", 32'(RegWriteW), 32'h0);
`else
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 32'h1);
        chk("mis_addr", dmem_addr, 32'h100);
        step();
        chk("mis_data", ReadDataW, 32'hCAFE_F00D);
        chk("mis_regwrite", 32'(RegWriteW), 32'h1);
`endif
        nop();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
